// File: rtl/ball_game_ctrl.sv
// ---------------------------------------------------------------------------
// ball_game_ctrl
// Per-frame game sequencer for the right-player board. Takes a ball handed
// over from the master board, moves it once per frame, judges paddle hits
// from camera pixels inside the ball box, keeps score and hands the ball
// back to the master.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   frame_tick          one-cycle pulse per frame (vblank start)
//   start               one-cycle game start/restart pulse
//   pixel_valid,
//   is_hit_area,
//   hit_pixel           per-pixel hit qualifiers from the camera path
//   ball_in_valid/_y/_dy_up   ball hand-over from master
//   ball_x, ball_y      ball top-left position
//   score               hits this game, saturating at MAX_SCORE
//   game_over, is_idle  decoded from the registered state
//   ball_out_valid/_y/_dy_up  ball hand-back to master (one-cycle pulse)
//   state_dbg           current FSM state encoding
//
// Handshake: ball_in_valid and ball_out_valid are single-cycle strobes with
// no back-pressure; the accompanying data is only meaningful in the cycle
// the strobe is high. ball_in_valid is accepted only in WAIT_BALL.
// ---------------------------------------------------------------------------
module ball_game_ctrl #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int BALL_SIZE  = 20,
    parameter int BALL_SPEED = 4,
    parameter int HIT_THRESH = 64,
    parameter int MAX_SCORE  = 99
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pixel_valid,
    input  logic       is_hit_area,
    input  logic       hit_pixel,
    input  logic       ball_in_valid,
    input  logic [9:0] ball_in_y,
    input  logic       ball_in_dy_up,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [7:0] score,
    output logic       game_over,
    output logic       is_idle,
    output logic       ball_out_valid,
    output logic [9:0] ball_out_y,
    output logic       ball_out_dy_up,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BALL = 3'd1,
        PLAY_IN   = 3'd2,
        PLAY_OUT  = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [10:0] X_MAX   = 11'(H_RES - BALL_SIZE);
    localparam logic [10:0] Y_MAX   = 11'(V_RES - BALL_SIZE);
    localparam logic [10:0] SPEED   = 11'(BALL_SPEED);
    localparam logic [9:0]  Y_RESET = 10'(V_RES / 2 - BALL_SIZE / 2);
    localparam logic [15:0] THRESH  = 16'(HIT_THRESH);
    localparam logic [7:0]  SCORE_MAX = 8'(MAX_SCORE);

    state_t      state, state_n;
    logic [9:0]  ball_x_n, ball_y_n;
    logic        dy_up, dy_up_n;
    logic [7:0]  score_n;
    logic [15:0] hit_cnt, hit_cnt_n;
    logic        ball_out_valid_n;
    logic [9:0]  ball_out_y_n;
    logic        ball_out_dy_up_n;

    // 11-bit views so boundary sums never wrap.
    logic [10:0] x_ext, y_ext;
    logic [9:0]  y_step;
    logic        dy_step;
    logic        hit_qual;

    assign x_ext    = {1'b0, ball_x};
    assign y_ext    = {1'b0, ball_y};
    assign hit_qual = pixel_valid & is_hit_area & hit_pixel;

    // Vertical step applied on every in-play tick, including the tick that
    // scores a hit or misses.
    always_comb begin
        y_step  = ball_y;
        dy_step = dy_up;
        if (!dy_up) begin
            if (y_ext + SPEED >= Y_MAX) begin
                y_step  = Y_MAX[9:0];
                dy_step = 1'b1;
            end else begin
                y_step = 10'(y_ext + SPEED);
            end
        end else begin
            if (y_ext <= SPEED) begin
                y_step  = 10'd0;
                dy_step = 1'b0;
            end else begin
                y_step = 10'(y_ext - SPEED);
            end
        end
    end

    always_comb begin
        state_n          = state;
        ball_x_n         = ball_x;
        ball_y_n         = ball_y;
        dy_up_n          = dy_up;
        score_n          = score;
        ball_out_valid_n = 1'b0;
        ball_out_y_n     = ball_out_y;
        ball_out_dy_up_n = ball_out_dy_up;

        // Counter is cleared by the tick; a qualifying pixel on the tick
        // cycle is intentionally dropped.
        hit_cnt_n = hit_cnt;
        if (frame_tick) begin
            hit_cnt_n = 16'd0;
        end else if (hit_qual && hit_cnt != 16'hFFFF) begin
            hit_cnt_n = hit_cnt + 16'd1;
        end

        case (state)
            IDLE, GAME_OVER: begin
                if (start) begin
                    score_n = 8'd0;
                    state_n = WAIT_BALL;
                end
            end
            WAIT_BALL: begin
                if (ball_in_valid) begin
                    ball_x_n = 10'd0;
                    ball_y_n = ({1'b0, ball_in_y} > Y_MAX) ? Y_MAX[9:0] : ball_in_y;
                    dy_up_n  = ball_in_dy_up;
                    state_n  = PLAY_IN;
                end
            end
            PLAY_IN: begin
                if (frame_tick) begin
                    ball_y_n = y_step;
                    dy_up_n  = dy_step;
                    if (hit_cnt >= THRESH) begin
                        score_n = (score >= SCORE_MAX) ? SCORE_MAX : score + 8'd1;
                        state_n = PLAY_OUT;
                    end else if (x_ext + SPEED >= X_MAX) begin
                        ball_x_n = X_MAX[9:0];
                        state_n  = GAME_OVER;
                    end else begin
                        ball_x_n = 10'(x_ext + SPEED);
                    end
                end
            end
            PLAY_OUT: begin
                if (frame_tick) begin
                    ball_y_n = y_step;
                    dy_up_n  = dy_step;
                    if (x_ext <= SPEED) begin
                        ball_x_n         = 10'd0;
                        ball_out_valid_n = 1'b1;
                        ball_out_y_n     = y_step;
                        ball_out_dy_up_n = dy_step;
                        state_n          = WAIT_BALL;
                    end else begin
                        ball_x_n = 10'(x_ext - SPEED);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ball_x         <= 10'd0;
            ball_y         <= Y_RESET;
            dy_up          <= 1'b0;
            score          <= 8'd0;
            hit_cnt        <= 16'd0;
            ball_out_valid <= 1'b0;
            ball_out_y     <= 10'd0;
            ball_out_dy_up <= 1'b0;
        end else begin
            state          <= state_n;
            ball_x         <= ball_x_n;
            ball_y         <= ball_y_n;
            dy_up          <= dy_up_n;
            score          <= score_n;
            hit_cnt        <= hit_cnt_n;
            ball_out_valid <= ball_out_valid_n;
            ball_out_y     <= ball_out_y_n;
            ball_out_dy_up <= ball_out_dy_up_n;
        end
    end

    assign is_idle   = (state == IDLE) || (state == WAIT_BALL);
    assign game_over = (state == GAME_OVER);
    assign state_dbg = state;

endmodule

// File: tb/tb_ball_game_ctrl.sv
module tb_ball_game_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_IN = 3'd2,
                           S_OUT = 3'd3, S_GO = 3'd4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_tick, start, pixel_valid, is_hit_area, hit_pixel;
    logic       ball_in_valid, ball_in_dy_up;
    logic [9:0] ball_in_y;
    logic [9:0] ball_x, ball_y, ball_out_y;
    logic [7:0] score;
    logic       game_over, is_idle, ball_out_valid, ball_out_dy_up;
    logic [2:0] state_dbg;

    int compared   = 0;
    int mismatched = 0;
    int pushed     = 0;
    int pulses     = 0;

    // Scoreboard of expected hand-backs: {dy_up, y}
    logic [10:0] exp_q[$];

    // Bench-side model of the vertical motion
    int m_y;
    bit m_dy;

    ball_game_ctrl dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .start(start),
        .pixel_valid(pixel_valid), .is_hit_area(is_hit_area), .hit_pixel(hit_pixel),
        .ball_in_valid(ball_in_valid), .ball_in_y(ball_in_y), .ball_in_dy_up(ball_in_dy_up),
        .ball_x(ball_x), .ball_y(ball_y), .score(score), .game_over(game_over),
        .is_idle(is_idle), .ball_out_valid(ball_out_valid), .ball_out_y(ball_out_y),
        .ball_out_dy_up(ball_out_dy_up), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hand-back monitor: each high sample must match the head of the queue.
    always @(negedge clk) begin
        if (reset_n && ball_out_valid) begin
            logic [10:0] e;
            pulses++;
            compared++;
            assert (exp_q.size() != 0) else begin
                mismatched++;
                $error("FAIL ball_out_unexpected observed=%0d expected=none", ball_out_y);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ball_out", {ball_out_dy_up, ball_out_y}, {21'd0, e});
            end
        end
    end

    // ---------------- model ----------------
    task automatic model_v();
        if (!m_dy) begin
            if (m_y + 4 >= 460) begin m_y = 460; m_dy = 1'b1; end
            else m_y = m_y + 4;
        end else begin
            if (m_y <= 4) begin m_y = 0; m_dy = 1'b0; end
            else m_y = m_y - 4;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic hand_in(input int y, input bit dy, input bit upd_model);
        ball_in_valid = 1'b1;
        ball_in_y     = 10'(y);
        ball_in_dy_up = dy;
        @(negedge clk);
        ball_in_valid = 1'b0;
        if (upd_model) begin
            m_y  = (y > 460) ? 460 : y;
            m_dy = dy;
        end
    endtask

    // n qualifying pixels, each followed by a random non-qualifying pattern
    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) begin
            {pixel_valid, is_hit_area, hit_pixel} = 3'b111;
            @(negedge clk);
            {pixel_valid, is_hit_area, hit_pixel} = 3'($urandom_range(0, 6));
            @(negedge clk);
        end
        {pixel_valid, is_hit_area, hit_pixel} = 3'b000;
    endtask

    // n frame ticks; move steps the y model; ret_last expects a hand-back
    // on the final tick; qual_tick drives a qualifying pixel with each tick.
    task automatic ticks(input int n, input bit move, input bit ret_last, input bit qual_tick);
        for (int i = 0; i < n; i++) begin
            if (move) model_v();
            if (ret_last && i == n - 1) begin
                exp_q.push_back({m_dy, 10'(m_y)});
                pushed++;
            end
            frame_tick = 1'b1;
            if (qual_tick) {pixel_valid, is_hit_area, hit_pixel} = 3'b111;
            @(negedge clk);
            frame_tick = 1'b0;
            {pixel_valid, is_hit_area, hit_pixel} = 3'b000;
            @(negedge clk);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        {frame_tick, start, pixel_valid, is_hit_area, hit_pixel} = 5'd0;
        ball_in_valid = 1'b0; ball_in_y = 10'd0; ball_in_dy_up = 1'b0;
        m_y = 230; m_dy = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_ball_x", ball_x, 0);
        chk("rst_ball_y", ball_y, 230);
        chk("rst_score", score, 0);
        chk("rst_is_idle", is_idle, 1);
        chk("rst_game_over", game_over, 0);
        chk("rst_out_valid", ball_out_valid, 0);
        chk("rst_out_y", ball_out_y, 0);
        chk("rst_state", state_dbg, S_IDLE);
        reset_n = 1'b1;
        @(negedge clk);

        // reset mid-PLAY_IN
        do_start();
        hand_in(100, 0, 1);
        ticks(25, 1, 0, 0);
        chk("pre_abort_x", ball_x, 100);
        chk("pre_abort_y", ball_y, m_y);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_x", ball_x, 0);
        chk("abort_y", ball_y, 230);
        chk("abort_idle", is_idle, 1);
        chk("abort_state", state_dbg, S_IDLE);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // entry and straight motion
        do_start();
        chk("start_state", state_dbg, S_WAIT);
        chk("start_score", score, 0);
        hand_in(100, 0, 1);
        chk("entry_state", state_dbg, S_IN);
        chk("entry_y", ball_y, 100);
        chk("entry_idle", is_idle, 0);
        ticks(5, 1, 0, 0);
        chk("move5_x", ball_x, 20);
        chk("move5_y", ball_y, 120);
        chk("move5_state", state_dbg, S_IN);

        // hit at x=40, return to master
        ticks(5, 1, 0, 0);
        chk("x40", ball_x, 40);
        pixels(64);
        ticks(1, 1, 0, 0);
        chk("hit_score", score, 1);
        chk("hit_state", state_dbg, S_OUT);
        chk("hit_x_hold", ball_x, 40);
        chk("hit_y", ball_y, m_y);
        ticks(9, 1, 0, 0);
        chk("ret_x4", ball_x, 4);
        ticks(1, 1, 1, 0);
        chk("ret_x0", ball_x, 0);
        chk("ret_idle", is_idle, 1);
        chk("ret_state", state_dbg, S_WAIT);

        // 63 pixels plus one on the tick cycle: no hit, then miss
        hand_in(200, 1, 1);
        pixels(63);
        ticks(1, 1, 0, 1);
        chk("nohit_score", score, 1);
        chk("nohit_state", state_dbg, S_IN);
        chk("nohit_x", ball_x, 4);
        ticks(153, 1, 0, 0);
        chk("edge_x616", ball_x, 616);
        ticks(1, 1, 0, 0);
        chk("miss_x", ball_x, 620);
        chk("miss_go", game_over, 1);
        chk("miss_y", ball_y, m_y);
        ticks(3, 0, 0, 0);
        chk("go_hold_x", ball_x, 620);
        chk("go_hold_y", ball_y, m_y);
        chk("go_hold_flag", game_over, 1);
        chk("go_hold_score", score, 1);
        do_start();
        chk("restart_score", score, 0);
        chk("restart_state", state_dbg, S_WAIT);
        chk("restart_go", game_over, 0);

        // clamp on entry, bottom and top bounces
        hand_in(600, 0, 1);
        chk("clamp_y", ball_y, 460);
        ticks(1, 1, 0, 0);
        chk("bottom_y", ball_y, 460);
        ticks(1, 1, 0, 0);
        chk("bottom_up_y", ball_y, 456);
        ticks(114, 1, 0, 0);
        chk("top_y", ball_y, 0);
        chk("top_x", ball_x, 464);
        ticks(1, 1, 0, 0);
        chk("top_down_y", ball_y, 4);

        // hit here, return, then many rounds up to saturation
        pixels(64);
        ticks(1, 1, 0, 0);
        chk("round_hit_score", score, 1);
        ticks(116, 1, 0, 0);
        chk("long_ret_x", ball_x, 4);
        ticks(1, 1, 1, 0);
        for (int r = 0; r < 98; r++) begin
            hand_in(int'($urandom_range(0, 700)), 1'($urandom_range(0, 1)), 1);
            pixels(64);
            ticks(1, 1, 0, 0);
            ticks(1, 1, 1, 0);
        end
        chk("score_99", score, 99);

        // one more hit saturates; ball_in ignored in PLAY_OUT
        hand_in(int'($urandom_range(0, 460)), 1'($urandom_range(0, 1)), 1);
        ticks(3, 1, 0, 0);
        chk("pre_sat_x", ball_x, 12);
        pixels(64);
        ticks(1, 1, 0, 0);
        chk("sat_score", score, 99);
        chk("sat_state", state_dbg, S_OUT);
        hand_in(50, 1, 0);
        chk("ign_state", state_dbg, S_OUT);
        chk("ign_x", ball_x, 12);
        chk("ign_y", ball_y, m_y);
        ticks(2, 1, 0, 0);
        chk("ign_x4", ball_x, 4);
        ticks(1, 1, 1, 0);
        chk("final_state", state_dbg, S_WAIT);
        chk("final_score", score, 99);

        repeat (4) @(negedge clk);
        chk("pulse_count", pulses, pushed);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
